// File: rtl/uart_reg_pkg.sv
// ============================================================================
// Module   : uart_reg_pkg
// Brief    : Shared constants, state encodings and command-byte builder for
//            the UART register-access host.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_reg_pkg;

    localparam logic [2:0] CMD_WR_PREFIX = 3'b101;
    localparam logic [2:0] CMD_RD_PREFIX = 3'b000;
    localparam int         ADDR_W        = 3;

    localparam int                 STATE_W      = 3;
    localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] ST_SEND_CMD  = 3'd1;
    localparam logic [STATE_W-1:0] ST_SEND_DATA = 3'd2;
    localparam logic [STATE_W-1:0] ST_WAIT_RX   = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE      = 3'd4;

    function automatic logic [7:0] build_cmd(input logic write, input logic [ADDR_W-1:0] addr);
        return {(write ? CMD_WR_PREFIX : CMD_RD_PREFIX), 2'b00, addr};
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rsp_timer.sv
// ============================================================================
// Module   : uart_rsp_timer
// Brief    : Clearable, saturating cycle counter with an expiry flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rsp_timer #(
    parameter int LIMIT = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expire
);

    localparam int             CNT_W  = $clog2(LIMIT + 1);
    localparam logic [CNT_W:0] c_last = (CNT_W + 1)'(LIMIT - 1);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W:0]   w_next;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Flags the cycle whose increment lands the count on LIMIT-1.
    assign w_next   = {1'b0, r_count} + 1'b1;
    assign o_expire = (w_next >= c_last);

endmodule

`default_nettype wire

// File: rtl/uart_reg_host.sv
// ============================================================================
// Module   : uart_reg_host
// Brief    : Host-side initiator for the UART register-access protocol.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_reg_host
    import uart_reg_pkg::*;
#(
    parameter int W_REG          = 32,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [W_REG-1:0]  req_wdata,
    output logic [7:0]        tx_byte,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    output logic              rsp_valid,
    output logic [W_REG-1:0]  rsp_rdata,
    output logic              rsp_err
);

    localparam int             N_BYTES    = W_REG / 8;
    localparam int             IDX_W      = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N_BYTES - 1);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_next;
    logic               r_write;
    logic [ADDR_W-1:0]  r_addr;
    logic [W_REG-1:0]   r_shift;
    logic [W_REG-1:0]   r_cap;
    logic [IDX_W-1:0]   r_idx;
    logic               r_tx_valid;
    logic [7:0]         r_tx_byte;
    logic [W_REG-1:0]   r_rsp_rdata;
    logic               r_rsp_err;

    logic               w_tx_hs;
    logic               w_rx_last;
    logic               w_expire;
    logic               w_timeout;
    logic [W_REG-1:0]   w_cap_next;

    assign w_tx_hs    = r_tx_valid && tx_ready;
    assign w_rx_last  = rx_valid && (r_idx == c_last_idx);
    assign w_timeout  = !rx_valid && w_expire;
    // Bytes arrive LSB first, so each new byte enters at the top and shifts down.
    assign w_cap_next = (r_cap >> 8) | (W_REG'(rx_byte) << (W_REG - 8));

    uart_rsp_timer #(
        .LIMIT    (TIMEOUT_CYCLES)
    ) u_rsp_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    ((r_state != ST_WAIT_RX) || rx_valid),
        .i_inc    ((r_state == ST_WAIT_RX) && !rx_valid),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:      if (req_valid) w_state_next = ST_SEND_CMD;
            ST_SEND_CMD:  if (w_tx_hs) w_state_next = r_write ? ST_SEND_DATA : ST_WAIT_RX;
            ST_SEND_DATA: if (w_tx_hs && (r_idx == c_last_idx)) w_state_next = ST_DONE;
            ST_WAIT_RX:   if (w_rx_last || w_timeout) w_state_next = ST_DONE;
            ST_DONE:      w_state_next = ST_IDLE;
            default:      w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (r_state == ST_IDLE);
        rsp_valid = (r_state == ST_DONE);
        tx_valid  = r_tx_valid;
        tx_byte   = r_tx_byte;
        rsp_rdata = r_rsp_rdata;
        rsp_err   = r_rsp_err;
    end

    // The first SEND_CMD cycle loads the command; the TX register is then
    // refilled directly from the shift register on every handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_shift     <= '0;
            r_cap       <= '0;
            r_idx       <= '0;
            r_tx_valid  <= 1'b0;
            r_tx_byte   <= 8'h00;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_write <= req_write;
                        r_addr  <= req_addr;
                        r_shift <= req_wdata;
                    end
                end
                ST_SEND_CMD: begin
                    if (!r_tx_valid) begin
                        r_tx_valid <= 1'b1;
                        r_tx_byte  <= build_cmd(r_write, r_addr);
                    end else if (tx_ready) begin
                        r_idx <= '0;
                        if (r_write) begin
                            r_tx_byte <= r_shift[7:0];
                            r_shift   <= r_shift >> 8;
                        end else begin
                            r_tx_valid <= 1'b0;
                            r_cap      <= '0;
                        end
                    end
                end
                ST_SEND_DATA: begin
                    if (w_tx_hs) begin
                        if (r_idx == c_last_idx) begin
                            r_tx_valid  <= 1'b0;
                            r_rsp_rdata <= '0;
                            r_rsp_err   <= 1'b0;
                        end else begin
                            r_idx     <= r_idx + 1'b1;
                            r_tx_byte <= r_shift[7:0];
                            r_shift   <= r_shift >> 8;
                        end
                    end
                end
                ST_WAIT_RX: begin
                    if (rx_valid) begin
                        r_cap <= w_cap_next;
                        r_idx <= r_idx + 1'b1;
                        if (w_rx_last) begin
                            r_rsp_rdata <= w_cap_next;
                            r_rsp_err   <= 1'b0;
                        end
                    end else if (w_expire) begin
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/uart_reg_host.md
Name: uart_reg_host

Overview:
- Host-side initiator for the UART register-access protocol; it is the requesting end, opposite the uart_regs register slave.
- Accepts one register read/write request at a time from local logic and serializes a command byte plus data bytes onto a byte-level TX stream.
- For reads, it collects the returned bytes from a byte-level RX stream, then reports a single response.
- Sits between a local controller (CPU/test sequencer) and a uart_core instance on the host side of the link.

Parameters:
- W_REG, 32, register width in bits; must be a multiple of 8. N_BYTES = W_REG/8 (derived localparam).
- TIMEOUT_CYCLES, 100000, clk cycles allowed between read-response bytes before aborting; must be ≥ 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  3  register index 0..7
- req_wdata  in  W_REG  write data; ignored for reads
- tx_byte  out  8  byte to uart_core transmitter
- tx_valid  out  1  tx_byte valid; held until accepted
- tx_ready  in  1  transmitter accepts tx_byte when tx_valid && tx_ready
- rx_byte  in  8  received byte from uart_core
- rx_valid  in  1  one-cycle pulse per received byte; no backpressure
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  W_REG  read data; 0 for writes and on error
- rsp_err  out  1  1 = read timed out

Behaviour:
- Reset (rst_n low at a clk edge, including mid-transaction): state=IDLE, req_ready=1, tx_valid=0, tx_byte=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. All counters and the capture register clear. Any in-flight byte is abandoned.
- Command byte = {prefix[2:0], 2'b00, addr[2:0]}. Write prefix = 3'b101; read prefix = 3'b000.
- Data order is LSB byte first for both directions.
- IDLE: req_ready=1. On acceptance, latch write/addr/wdata, drop req_ready, and go to SEND_CMD. tx_valid rises on the next cycle carrying the command byte.
- SEND_CMD: hold tx_byte/tx_valid stable until a tx handshake occurs.
  - Write: go to SEND_DATA with byte index 0.
  - Read: go to WAIT_RX with byte count 0 and the timer cleared.
- SEND_DATA: tx_byte = wdata[8*i+7:8*i]. On each handshake, i increments. tx_valid stays high across back-to-back bytes (the next byte is presented the cycle after a handshake).
  - After the handshake of byte N_BYTES-1, go to DONE with rsp_err=0 and rsp_rdata=0.
- WAIT_RX: tx_valid=0. On rx_valid, capture rx_byte into byte slot count, increment count, and clear the timer. Otherwise the timer increments.
  - Count reaching N_BYTES: go to DONE with rsp_rdata=assembled word and rsp_err=0.
  - Timer reaching TIMEOUT_CYCLES-1 with no rx_valid that cycle: go to DONE with rsp_err=1 and rsp_rdata=0.
  - rx_valid arriving in the same cycle as timer expiry counts as a byte; the timeout does not fire.
- DONE: rsp_valid=1 for exactly one cycle, then go to IDLE. rsp_rdata/rsp_err hold their values until the next DONE.
- rx_valid outside WAIT_RX (including the SEND_CMD handshake cycle) is ignored.
- Latency, write: request acceptance to rsp_valid = 1 + (N_BYTES+1) handshakes + 1 cycle, with tx_ready held high: 7 cycles for W_REG=32.
- A new request can be accepted on the cycle after rsp_valid.
- Timer width: $clog2(TIMEOUT_CYCLES+1). The timer saturates and never wraps.

Decomposition:
- Package uart_reg_pkg holds:
  - CMD_WR_PREFIX=3'b101 and CMD_RD_PREFIX=3'b000
  - ADDR_W=3
  - state encodings IDLE/SEND_CMD/SEND_DATA/WAIT_RX/DONE
  - the command-byte build function
- One sub-module, uart_rsp_timer: a clearable, saturating cycle counter with an expiry flag. It is instantiated for the read timeout.

Test Plan:
- Write, tx_ready=1: addr=3, wdata=32'hDEADBEEF -> tx bytes A3, EF, BE, AD, DE. Then rsp_valid pulses once with rsp_err=0, 7 cycles after acceptance.
- Read: addr=5 -> tx byte 05. Inject rx bytes 78, 56, 34, 12 with random gaps below the timeout -> rsp_rdata=32'h12345678, rsp_err=0.
- Backpressure: write with tx_ready toggling randomly -> tx_byte stable while tx_valid && !tx_ready, no byte skipped or duplicated, same five-byte sequence.
- Timeout, TIMEOUT_CYCLES=20: read, send 2 bytes then stop -> rsp_err=1 and rsp_rdata=0 exactly 20 cycles after the last byte. A stray rx byte afterwards is ignored.
- Reset mid-read: drop rst_n after 2 response bytes -> next edge gives IDLE, req_ready=1, tx_valid=0. A following read of addr=0 returns fresh data only.
- Stray rx_valid in IDLE plus req_valid held high after completion -> stray byte ignored; second request accepted the cycle after rsp_valid.
